axi_cmd_master: RTL

//  Upstream AXI-lite-style master for tt_um_thejesvinii_axi: turns simple user commands (write/read, 4b addr, 4b data) into slave handshakes.

---
 rtl/axi_cmd_master.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_cmd_master.sv
// axi_cmd_master: issues AXI-lite-style write/read handshakes for simple commands, with a per-transaction timeout.
// Define CMD_FIFO_EN for a 2-entry command buffer that accepts commands while a transaction is in flight.
module axi_cmd_master #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int RDATA_W = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [DATA_W-1:0]  cmd_data,
  output logic               ms_awvalid,
  input  logic               sm_awready,
  output logic               ms_wvalid,
  input  logic               sm_wready,
  output logic [DATA_W-1:0]  SWM_wdata,
  output logic               ms_arvalid,
  input  logic               sm_arready,
  output logic [ADDR_W-1:0]  SWM_arADDR,
  output logic               ms_rready,
  input  logic               sm_rvalid,
  input  logic [RDATA_W-1:0] disp_hex_r,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [RDATA_W-1:0] rsp_data,
  output logic               busy
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_A,
    S_RD_D,
    S_RESP
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_idle_rdy;
  logic               r_busy;
  logic               r_awvalid;
  logic               r_wvalid;
  logic               r_arvalid;
  logic               r_rready;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic [RDATA_W-1:0] r_rsp_data;

  logic               w_cmd_vld;
  logic               w_cmd_write;
  logic [ADDR_W-1:0]  w_cmd_addr;
  logic [DATA_W-1:0]  w_cmd_data;
  logic               w_take;
  logic               w_aw_hs;
  logic               w_w_hs;
  logic               w_ar_hs;
  logic               w_r_hs;
  logic               w_expire;

`ifdef CMD_FIFO_EN
  localparam int CMD_W = 1 + ADDR_W + DATA_W;

  logic [CMD_W-1:0] r_fifo [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_out_en;
  logic             w_push;
  logic             w_full;

  assign w_full    = (r_count == 2'd2);
  // Held low while in reset so every output reads 0 until the first edge after release.
  assign cmd_ready = r_out_en & ~w_full;
  assign w_push    = cmd_valid & cmd_ready;
  assign w_cmd_vld = (r_count != 2'd0);
  assign {w_cmd_write, w_cmd_addr, w_cmd_data} = r_fifo[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {cmd_write, cmd_addr, cmd_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_out_en <= 1'b0;
    end else begin
      r_out_en <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_take) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_take};
    end
  end
`else
  assign cmd_ready   = r_idle_rdy;
  assign w_cmd_vld   = cmd_valid;
  assign w_cmd_write = cmd_write;
  assign w_cmd_addr  = cmd_addr;
  assign w_cmd_data  = cmd_data;
`endif

  // r_idle_rdy tracks "in IDLE and out of reset", so it gates command pickup in both builds.
  assign w_take   = r_idle_rdy & w_cmd_vld;
  assign w_aw_hs  = r_awvalid & sm_awready;
  assign w_w_hs   = r_wvalid & sm_wready;
  assign w_ar_hs  = r_arvalid & sm_arready;
  assign w_r_hs   = r_rready & sm_rvalid;
  assign w_expire = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idle_rdy  <= 1'b0;
      r_busy      <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_idle_rdy <= 1'b1;
          if (w_take) begin
            r_idle_rdy <= 1'b0;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_addr     <= w_cmd_addr;
            if (w_cmd_write) begin
              r_wdata   <= w_cmd_data;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_A;
            end
          end
        end

        S_WR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
          end
          // A channel whose valid is already low has completed its handshake.
          if ((!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs)) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_expire) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_rsp_data  <= '1;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_RD_A: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_RD_D;
          end else if (w_expire) begin
            r_arvalid   <= 1'b0;
            r_rsp_data  <= '1;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_RD_D: begin
          if (w_r_hs) begin
            r_rready    <= 1'b0;
            r_rsp_data  <= disp_hex_r;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_expire) begin
            r_rready    <= 1'b0;
            r_rsp_data  <= '1;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_RESP: begin
          r_busy     <= 1'b0;
          r_idle_rdy <= 1'b1;
          r_state    <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ms_awvalid = r_awvalid;
  assign ms_wvalid  = r_wvalid;
  assign ms_arvalid = r_arvalid;
  assign ms_rready  = r_rready;
  assign SWM_arADDR = r_addr;
  assign SWM_wdata  = r_wdata;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_err    = r_rsp_err;
  assign rsp_data   = r_rsp_data;
  assign busy       = r_busy;

endmodule
